timer_irq_source: RTL and testbench

- Memory-mapped timer peripheral that generates the IRQ consumed by the CPU control decoder.
- It is the producer end of the interrupt interface: it raises IRQ on timer overflow and holds it until the kernel handler clears it with a store.
- It sits on the single-cycle data bus beside data memory.
- Reads are combinational, so lw completes in one cycle. Writes commit on the clock edge.

---
 rtl/timer_irq_source.sv | 111 +++++++++++
 tb/tb_timer_irq_source.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// Memory-mapped timer peripheral on the single-cycle data bus.
// When TL overflows it raises a registered IRQ. The IRQ holds until software clears TCON[2].
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] TH_RESET  = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

  localparam logic [2:0] SEL_TH      = 3'd0;
  localparam logic [2:0] SEL_TL      = 3'd1;
  localparam logic [2:0] SEL_TCON    = 3'd2;
  localparam logic [2:0] SEL_SYSTICK = 3'd5;

  logic [31:0] regTh;
  logic [31:0] regTl;
  logic [2:0]  regTcon;
  logic [31:0] sysTick;
  logic [15:0] prescaleCnt;

  logic        hit;
  logic [2:0]  wordSel;
  logic        wrTh;
  logic        wrTl;
  logic        wrTcon;
  logic        tick;
  logic        overflow;
  logic        setStatus;

  // A hit requires the 32-byte window to match and a word-aligned address.
  assign hit      = (Addr[31:5] == BASE_ADDR[31:5]) && (Addr[1:0] == 2'b00);
  assign wordSel  = Addr[4:2];
  assign wrTh     = MemWrite && hit && (wordSel == SEL_TH);
  assign wrTl     = MemWrite && hit && (wordSel == SEL_TL);
  assign wrTcon   = MemWrite && hit && (wordSel == SEL_TCON);

  assign tick      = regTcon[0] && (prescaleCnt == PRESCALE_MAX);
  assign overflow  = tick && (regTl == 32'hFFFF_FFFF);
  assign setStatus = overflow && regTcon[1];

  assign IRQ = regTcon[2];

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && hit) begin
      case (wordSel)
        SEL_TH:      ReadData = regTh;
        SEL_TL:      ReadData = regTl;
        SEL_TCON:    ReadData = {29'b0, regTcon};
        SEL_SYSTICK: ReadData = sysTick;
        default:     ReadData = 32'h0;
      endcase
    end
  end

  // The prescaler freezes while TCON[0] is clear. Re-enabling resumes from the held count.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaleCnt <= 16'd0;
    end else if (regTcon[0]) begin
      prescaleCnt <= (prescaleCnt == PRESCALE_MAX) ? 16'd0 : prescaleCnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sysTick <= 32'h0;
    end else begin
      sysTick <= sysTick + 32'd1;
    end
  end

  // A software write to TL beats a tick in the same cycle. A reload uses TH as it was before any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      regTh <= TH_RESET;
      regTl <= TH_RESET;
    end else begin
      if (wrTh) begin
        regTh <= WriteData;
      end
      if (wrTl) begin
        regTl <= WriteData;
      end else if (tick) begin
        regTl <= overflow ? regTh : regTl + 32'd1;
      end
    end
  end

  // An overflow that sets status outranks a software clear in the same cycle, so no interrupt is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      regTcon <= 3'b000;
    end else if (wrTcon) begin
      regTcon <= {WriteData[2] | setStatus, WriteData[1:0]};
    end else if (setStatus) begin
      regTcon[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed scoreboard bench for timer_irq_source. It drives two instances (PRESCALE=1 and PRESCALE=4) from one shared bus.
`timescale 1ns/1ps
module tb_timer_irq_source;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;
  localparam logic [31:0] TH_RST    = 32'hFFFF_F000;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } ExpectEntry;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] rdata1;
  logic [31:0] rdata4;
  logic        irq1;
  logic        irq4;
  logic [31:0] sysModel;

  ExpectEntry  scoreboard[$];
  int          testCount = 0;
  int          failCount = 0;

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1), .TH_RESET(TH_RST)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(rdata1), .IRQ(irq1)
  );

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4), .TH_RESET(TH_RST)) dut4 (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(rdata4), .IRQ(irq4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference for SYSTICK: the number of clock edges since reset was last released.
  always @(posedge clk) begin
    if (reset) sysModel <= 32'h0;
    else       sysModel <= sysModel + 32'd1;
  end

  task automatic expectValue(input string tag, input logic [31:0] value);
    ExpectEntry e;
    e.tag   = tag;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    ExpectEntry e;
    testCount++;
    if (scoreboard.size() == 0) begin
      failCount++;
      $error("FAIL scoreboard-empty: observed %h, required a queued expectation", observed);
    end else begin
      e = scoreboard.pop_front();
      assert (observed === e.value) else begin
        failCount++;
        $error("FAIL %s: observed %h, expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  // Drive one bus cycle at the negedge. Sample ReadData before the commit edge, then return at the next negedge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] preRead);
    MemWrite  = wr;
    MemRead   = rd;
    Addr      = addr;
    WriteData = data;
    #1;
    preRead = rdata1;
    @(negedge clk);
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Addr      = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] unused;
    applyStimulus(1'b1, 1'b0, addr, data, unused);
  endtask

  task automatic idleCycles(input int n);
    logic [31:0] unused;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, unused);
  endtask

  task automatic checkReg(input string tag, input bit onDut4, input logic [31:0] addr,
                          input logic [31:0] value);
    logic [31:0] data;
    expectValue(tag, value);
    Addr    = addr;
    MemRead = 1'b1;
    #1;
    data    = onDut4 ? rdata4 : rdata1;
    MemRead = 1'b0;
    Addr    = 32'h0;
    checkOutput(data);
  endtask

  task automatic checkIrq(input string tag, input bit onDut4, input logic value);
    expectValue(tag, {31'b0, value});
    checkOutput({31'b0, onDut4 ? irq4 : irq1});
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pre;
    logic [31:0] tickStart;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkIrq("irq-after-reset", 0, 1'b0);
    checkReg("th-reset", 0, A_TH, TH_RST);
    checkReg("tl-reset", 0, A_TL, TH_RST);
    checkReg("tcon-reset", 0, A_TCON, 32'h0);

    // Reset drops a pending IRQ.
    writeReg(A_TCON, 32'h7);
    checkIrq("irq-forced", 0, 1'b1);
    doReset();
    checkIrq("irq-dropped-by-reset", 0, 1'b0);
    checkReg("tl-after-reset", 0, A_TL, TH_RST);
    checkReg("th-after-reset", 0, A_TH, TH_RST);
    checkReg("tcon-after-reset", 0, A_TCON, 32'h0);

    // PRESCALE=1 counting to overflow (period of 4 ticks).
    writeReg(A_TH, 32'hFFFF_FFFC);
    writeReg(A_TL, 32'hFFFF_FFFC);
    writeReg(A_TCON, 32'h3);
    checkReg("tl-start", 0, A_TL, 32'hFFFF_FFFC);
    idleCycles(1); checkReg("tl-fd", 0, A_TL, 32'hFFFF_FFFD);
    idleCycles(1); checkReg("tl-fe", 0, A_TL, 32'hFFFF_FFFE);
    idleCycles(1); checkReg("tl-ff", 0, A_TL, 32'hFFFF_FFFF); checkIrq("irq-before-ovf", 0, 1'b0);
    idleCycles(1); checkReg("tl-reload", 0, A_TL, 32'hFFFF_FFFC); checkIrq("irq-at-ovf", 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      idleCycles(1);
      checkIrq("irq-held", 0, 1'b1);
    end

    // Software clears status. The next overflow comes 4 cycles after the previous one.
    writeReg(A_TCON, 32'h3);
    checkIrq("irq-cleared", 0, 1'b0);
    checkReg("tl-after-clear", 0, A_TL, 32'hFFFF_FFFD);
    idleCycles(2); checkIrq("irq-still-clear", 0, 1'b0); checkReg("tl-ff-2", 0, A_TL, 32'hFFFF_FFFF);
    idleCycles(1); checkIrq("irq-reraised", 0, 1'b1);

    // A clear that coincides with an overflow: the set wins.
    writeReg(A_TCON, 32'h3);
    checkIrq("irq-cleared-2", 0, 1'b0);
    idleCycles(2); checkReg("tl-ff-3", 0, A_TL, 32'hFFFF_FFFF);
    writeReg(A_TCON, 32'h3);
    checkIrq("set-wins-irq", 0, 1'b1);
    checkReg("set-wins-tcon", 0, A_TCON, 32'h7);
    checkReg("set-wins-tl", 0, A_TL, 32'hFFFF_FFFC);

    // A TL write that coincides with an overflow: the write wins.
    idleCycles(3);
    writeReg(A_TL, 32'h0000_0010);
    checkReg("tl-write-wins", 0, A_TL, 32'h0000_0010);

    // A TH write (combined with a read) at a reload: TL takes the old TH. The new TH applies at the next reload.
    writeReg(A_TL, 32'hFFFF_FFFF);
    checkReg("tl-preset-ff", 0, A_TL, 32'hFFFF_FFFF);
    expectValue("rw-pre-write-th", 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, A_TH, 32'h0000_0100, pre);
    checkOutput(pre);
    checkReg("reload-old-th", 0, A_TL, 32'hFFFF_FFFC);
    checkReg("th-new", 0, A_TH, 32'h0000_0100);
    idleCycles(4);
    checkReg("reload-new-th", 0, A_TL, 32'h0000_0100);

    // PRESCALE=4 instance: slow ticks, overflow with irq disabled, freeze/resume.
    doReset();
    writeReg(A_TL, 32'h0);
    writeReg(A_TCON, 32'h1);
    idleCycles(3); checkReg("ps4-tl-0", 1, A_TL, 32'h0);
    idleCycles(1); checkReg("ps4-tl-1", 1, A_TL, 32'h1);
    idleCycles(3); checkReg("ps4-tl-1b", 1, A_TL, 32'h1);
    idleCycles(1); checkReg("ps4-tl-2", 1, A_TL, 32'h2);
    writeReg(A_TL, 32'hFFFF_FFFF);
    idleCycles(2); checkReg("ps4-tl-ff", 1, A_TL, 32'hFFFF_FFFF);
    idleCycles(1); checkReg("ps4-reload", 1, A_TL, TH_RST);
    checkIrq("ps4-no-irq", 1, 1'b0);
    checkReg("ps4-tcon", 1, A_TCON, 32'h1);
    writeReg(A_TCON, 32'h0);
    idleCycles(10); checkReg("ps4-frozen", 1, A_TL, TH_RST);
    writeReg(A_TCON, 32'h1);
    idleCycles(2); checkReg("ps4-resume-hold", 1, A_TL, TH_RST);
    idleCycles(1); checkReg("ps4-resume-tick", 1, A_TL, TH_RST + 32'd1);

    // SYSTICK is free-running and read-only.
    tickStart = sysModel;
    checkReg("systick-a", 0, A_SYSTICK, tickStart);
    idleCycles(100);
    checkReg("systick-b", 0, A_SYSTICK, tickStart + 32'd100);
    writeReg(A_SYSTICK, 32'h0);
    checkReg("systick-ro", 0, A_SYSTICK, sysModel);

    // Unmapped and misaligned accesses are ignored.
    doReset();
    writeReg(32'h4000_000C, 32'h1234_5678);
    writeReg(32'h4000_0009, 32'h7);
    writeReg(32'h4000_0001, 32'hDEAD_BEEF);
    checkReg("unmapped-th", 0, A_TH, TH_RST);
    checkReg("unmapped-tl", 0, A_TL, TH_RST);
    checkReg("unmapped-tcon", 0, A_TCON, 32'h0);
    checkIrq("unmapped-irq", 0, 1'b0);
    idleCycles(1);
    checkReg("read-0c", 0, 32'h4000_000C, 32'h0);
    checkReg("read-09", 0, 32'h4000_0009, 32'h0);
    checkReg("read-outside", 0, 32'h4000_0020, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
